// File: rtl/ibex_rvfi_trace_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rvfi_trace_buf_if
// Description : Control, RVFI capture, drain and status bundle for the trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ibex_rvfi_trace_buf_if #(
    parameter int DEPTH = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // capture control
    logic             arm;
    logic             mode;
    logic             abort;
    logic             trig_pc_en;
    logic [31:0]      trig_pc;
    logic             trig_trap_en;
    // retirement stream
    logic             rvfi_valid;
    logic [31:0]      rvfi_pc_rdata;
    logic [31:0]      rvfi_insn;
    logic [4:0]       rvfi_rd_addr;
    logic [31:0]      rvfi_rd_wdata;
    logic             rvfi_trap;
    logic             rvfi_intr;
    // drain port
    logic             rd_valid;
    logic             rd_ready;
    logic [31:0]      rd_pc;
    logic [31:0]      rd_insn;
    logic [31:0]      rd_wdata;
    logic [4:0]       rd_rd_addr;
    logic             rd_trap;
    logic             rd_intr;
    // status
    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             trig_hit;
    logic             overflow;

    modport master (
        output arm, mode, abort, trig_pc_en, trig_pc, trig_trap_en,
        output rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata, rvfi_trap, rvfi_intr,
        output rd_ready,
        input  rd_valid, rd_pc, rd_insn, rd_wdata, rd_rd_addr, rd_trap, rd_intr,
        input  state, count, trig_hit, overflow
    );

    modport slave (
        input  arm, mode, abort, trig_pc_en, trig_pc, trig_trap_en,
        input  rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata, rvfi_trap, rvfi_intr,
        input  rd_ready,
        output rd_valid, rd_pc, rd_insn, rd_wdata, rd_rd_addr, rd_trap, rd_intr,
        output state, count, trig_hit, overflow
    );
endinterface
`default_nettype wire

// File: rtl/ibex_rvfi_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rvfi_trace_buf
// Description : RVFI retirement capture buffer, stop-on-full or ring-with-trigger,
//               drained oldest-first over a valid/ready port once capture stops.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rvfi_trace_buf #(
    parameter int DEPTH         = 32,
    parameter int POST_TRIG_CNT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ibex_rvfi_trace_buf_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] C_FULL      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_LAST_FREE = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] C_POST_LOAD = PTR_W'(POST_TRIG_CNT);
    localparam logic [PTR_W-1:0] C_POST_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] wdata;
        logic        trap;
        logic        intr;
    } rec_t;

    state_t           r_state;
    logic             r_mode;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_post;
    logic [CNT_W-1:0] r_count;
    logic             r_trig_hit;
    logic             r_overflow;
    rec_t             r_mem [DEPTH];

    logic w_capturing;
    logic w_wr_en;
    logic w_trig;
    logic w_rd_valid;
    logic w_pop;
    rec_t w_wr_rec;
    rec_t w_head;

    always_comb begin
        w_capturing = (r_state == S_ARMED) || (r_state == S_POST);
        // abort wins over a retirement in the same cycle
        w_wr_en     = w_capturing && bus.rvfi_valid && !bus.abort;
        w_trig      = bus.rvfi_valid &&
                      ((bus.trig_pc_en && (bus.rvfi_pc_rdata == bus.trig_pc)) ||
                       (bus.trig_trap_en && bus.rvfi_trap));
        w_rd_valid  = (r_state == S_DONE) && (r_count != '0);
        w_pop       = w_rd_valid && bus.rd_ready;
        w_wr_rec    = '{pc:      bus.rvfi_pc_rdata,
                        insn:    bus.rvfi_insn,
                        rd_addr: bus.rvfi_rd_addr,
                        wdata:   bus.rvfi_rd_wdata,
                        trap:    bus.rvfi_trap,
                        intr:    bus.rvfi_intr};
        w_head      = w_rd_valid ? r_mem[r_rd_ptr] : '0;
    end

    // record storage carries no reset; validity is tracked by the count
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_rec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_post     <= '0;
            r_count    <= '0;
            r_trig_hit <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.arm) begin
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_post     <= '0;
                        r_count    <= '0;
                        r_trig_hit <= 1'b0;
                        r_overflow <= 1'b0;
                        r_mode     <= bus.mode;
                        r_state    <= S_ARMED;
                    end else if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_count  <= r_count - 1'b1;
                    end
                end
                S_ARMED, S_POST: begin
                    if (bus.abort) begin
                        r_state <= S_DONE;
                    end else if (bus.rvfi_valid) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        // only ring mode can reach a write while full
                        if (r_count != C_FULL) begin
                            r_count <= r_count + 1'b1;
                        end else begin
                            r_rd_ptr   <= r_rd_ptr + 1'b1;
                            r_overflow <= 1'b1;
                        end
                        if (r_state == S_ARMED) begin
                            if (w_trig) begin
                                r_trig_hit <= 1'b1;
                                if (r_mode) begin
                                    r_post  <= C_POST_LOAD;
                                    r_state <= (POST_TRIG_CNT == 0) ? S_DONE : S_POST;
                                end else begin
                                    r_state <= S_DONE;
                                end
                            end else if (!r_mode && (r_count == C_LAST_FREE)) begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_post <= r_post - 1'b1;
                            if (r_post == C_POST_ONE) begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_valid   = w_rd_valid;
    assign bus.rd_pc      = w_head.pc;
    assign bus.rd_insn    = w_head.insn;
    assign bus.rd_wdata   = w_head.wdata;
    assign bus.rd_rd_addr = w_head.rd_addr;
    assign bus.rd_trap    = w_head.trap;
    assign bus.rd_intr    = w_head.intr;
    assign bus.state      = r_state;
    assign bus.count      = r_count;
    assign bus.trig_hit   = r_trig_hit;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ibex_rvfi_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_rvfi_trace_buf
// Description : Directed and random capture/drain scenarios against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_rvfi_trace_buf;

    localparam int DEPTH = 32;
    localparam int PTC   = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] wdata;
        logic        trap;
        logic        intr;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ibex_rvfi_trace_buf_if #(.DEPTH(DEPTH)) bus ();

    ibex_rvfi_trace_buf #(.DEPTH(DEPTH), .POST_TRIG_CNT(PTC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    // reference model: buffer contents as a plain queue, states as numbered 0..3
    int   m_state = 0;
    bit   m_mode  = 1'b0;
    int   m_post  = 0;
    bit   m_trig  = 1'b0;
    bit   m_ovf   = 1'b0;
    rec_t q[$];
    rec_t sb_q[$];
    rec_t popped[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic enter_done();
        m_state = 3;
        sb_q    = q;
    endtask

    task automatic model_update();
        rec_t r;
        bit   hit;
        if (rst) begin
            m_state = 0; m_trig = 0; m_ovf = 0; m_post = 0;
            q.delete(); sb_q.delete();
        end else if (m_state == 0 || m_state == 3) begin
            if (bus.arm) begin
                q.delete(); sb_q.delete();
                m_trig = 0; m_ovf = 0; m_mode = bus.mode; m_state = 1;
            end else if (m_state == 3 && q.size() > 0 && bus.rd_ready) begin
                void'(q.pop_front());
            end
        end else if (bus.abort) begin
            enter_done();
        end else if (bus.rvfi_valid) begin
            r = '{pc: bus.rvfi_pc_rdata, insn: bus.rvfi_insn, rd_addr: bus.rvfi_rd_addr,
                  wdata: bus.rvfi_rd_wdata, trap: bus.rvfi_trap, intr: bus.rvfi_intr};
            q.push_back(r);
            if (q.size() > DEPTH) begin
                void'(q.pop_front());
                m_ovf = 1;
            end
            hit = (bus.trig_pc_en && bus.rvfi_pc_rdata == bus.trig_pc) ||
                  (bus.trig_trap_en && bus.rvfi_trap);
            if (m_state == 1 && hit) begin
                m_trig = 1;
                if (!m_mode || PTC == 0) enter_done();
                else begin m_post = PTC; m_state = 2; end
            end else if (m_state == 1 && !m_mode && q.size() == DEPTH) begin
                enter_done();
            end else if (m_state == 2) begin
                m_post--;
                if (m_post == 0) enter_done();
            end
        end
    endtask

    // monitor: status against the model, drained records against the scoreboard
    always @(negedge clk) begin
        rec_t e;
        if (mon_en) begin
            chk("state", 32'(bus.state), 32'(m_state));
            chk("count", 32'(bus.count), 32'(q.size()));
            chk("trig_hit", 32'(bus.trig_hit), 32'(m_trig));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("rd_valid", 32'(bus.rd_valid), 32'(m_state == 3 && q.size() != 0));
            if (bus.rd_valid) begin
                if (bus.rd_ready) begin
                    if (sb_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL pop_extra: got pc %h expected no record", bus.rd_pc);
                    end else begin
                        e = sb_q.pop_front();
                        chk("pop_pc", bus.rd_pc, e.pc);
                        chk("pop_insn", bus.rd_insn, e.insn);
                        chk("pop_wdata", bus.rd_wdata, e.wdata);
                        chk("pop_misc", 32'({bus.rd_rd_addr, bus.rd_trap, bus.rd_intr}),
                                        32'({e.rd_addr, e.trap, e.intr}));
                    end
                end
            end else begin
                chk("rd_zero", bus.rd_pc | bus.rd_insn | bus.rd_wdata |
                               32'({bus.rd_rd_addr, bus.rd_trap, bus.rd_intr}), 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic trap);
        bus.rvfi_pc_rdata = pc;
        bus.rvfi_insn     = $urandom;
        bus.rvfi_rd_addr  = 5'($urandom_range(0, 31));
        bus.rvfi_rd_wdata = $urandom;
        bus.rvfi_trap     = trap;
        bus.rvfi_intr     = 1'($urandom_range(0, 1));
    endtask

    task automatic retire(input logic [31:0] pc, input logic trap);
        bus.rvfi_valid = 1'b1;
        set_rec(pc, trap);
        tick();
        bus.rvfi_valid = 1'b0;
    endtask

    // the arm cycle carries a random retirement that must not be captured
    task automatic arm(input logic mode);
        bus.arm        = 1'b1;
        bus.mode       = mode;
        bus.rvfi_valid = 1'($urandom_range(0, 1));
        set_rec(32'h0, 1'b0);
        tick();
        bus.arm        = 1'b0;
        bus.rvfi_valid = 1'b0;
    endtask

    // pattern 0: always ready, 1: 1010..., 2: random
    task automatic drain(input int pattern);
        int i = 0;
        popped.delete();
        while (q.size() > 0 && i < 300) begin
            bus.rd_ready   = (pattern == 0) ? 1'b1 : (pattern == 1) ? 1'(i % 2 == 0) : 1'($urandom_range(0, 1));
            bus.rvfi_valid = 1'($urandom_range(0, 1));
            set_rec(32'($urandom_range(0, 63)) << 2, 1'b0);
            if (bus.rd_valid && bus.rd_ready)
                popped.push_back('{pc: bus.rd_pc, insn: bus.rd_insn, rd_addr: bus.rd_rd_addr,
                                   wdata: bus.rd_wdata, trap: bus.rd_trap, intr: bus.rd_intr});
            tick();
            i++;
        end
        bus.rd_ready   = 1'b0;
        bus.rvfi_valid = 1'b0;
        if (i >= 300) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d records left expected 0", q.size());
        end
        tick();
    endtask

    task automatic set_trig(input logic pc_en, input logic [31:0] pc, input logic trap_en);
        bus.trig_pc_en   = pc_en;
        bus.trig_pc      = pc;
        bus.trig_trap_en = trap_en;
    endtask

    initial begin
        int n;
        bus.arm = 0; bus.mode = 0; bus.abort = 0; bus.rd_ready = 0;
        bus.rvfi_valid = 0;
        set_trig(1'b0, 32'h0, 1'b0);
        set_rec(32'h0, 1'b0);

        // reset
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_flags", 32'({bus.rd_valid, bus.trig_hit, bus.overflow}), 32'd0);
        rst = 1'b0;
        tick();

        // stop-on-full
        arm(1'b0);
        for (int k = 0; k < 40; k++) begin
            retire(32'h100 + 32'(4 * k), 1'b0);
            if (k == 30) chk("sf_not_done_31", 32'(bus.state), 32'd1);
            if (k == 31) chk("sf_done_32", 32'(bus.state), 32'd3);
        end
        chk("sf_count", 32'(bus.count), 32'd32);
        chk("sf_overflow", 32'(bus.overflow), 32'd0);
        drain(0);
        chk("sf_pops", 32'(popped.size()), 32'd32);
        foreach (popped[k]) chk("sf_order", popped[k].pc, 32'h100 + 32'(4 * k));

        // ring with pc trigger
        set_trig(1'b1, 32'h200, 1'b0);
        arm(1'b1);
        n = 0;
        while (bus.state != 2'd3 && n < 300) begin
            retire(32'(4 * n), 1'b0);
            n++;
        end
        chk("ring_last_pc", 32'(4 * (n - 1)), 32'h220);
        chk("ring_count", 32'(bus.count), 32'd32);
        chk("ring_head", bus.rd_pc, 32'h1A4);
        chk("ring_flags", 32'({bus.trig_hit, bus.overflow}), 32'b11);
        drain(1);
        chk("ring_pops", 32'(popped.size()), 32'd32);
        foreach (popped[k]) chk("ring_order", popped[k].pc, 32'h1A4 + 32'(4 * k));

        // trap trigger in stop-on-full mode
        set_trig(1'b0, 32'h0, 1'b1);
        arm(1'b0);
        for (int k = 0; k < 4; k++) retire(32'h300 + 32'(4 * k), 1'b0);
        retire(32'h310, 1'b1);
        chk("trap_done", 32'(bus.state), 32'd3);
        chk("trap_count", 32'(bus.count), 32'd5);
        drain(2);
        chk("trap_last", 32'({popped[$].pc, popped[$].trap}), {32'h310, 1'b1} >> 0 & 32'hFFFFFFFF);

        // abort beats a coincident retirement
        set_trig(1'b0, 32'h0, 1'b0);
        arm(1'b1);
        for (int k = 0; k < 3; k++) retire(32'h400 + 32'(4 * k), 1'b0);
        bus.abort = 1'b1;
        retire(32'h40C, 1'b0);
        bus.abort = 1'b0;
        chk("abort_state", 32'(bus.state), 32'd3);
        chk("abort_count", 32'(bus.count), 32'd3);
        chk("abort_trig", 32'(bus.trig_hit), 32'd0);
        drain(1);

        // reset while in the post-trigger window
        set_trig(1'b1, 32'h34, 1'b0);
        arm(1'b1);
        for (int k = 0; k < 20; k++) retire(32'(4 * k), 1'b0);
        chk("post_state", 32'(bus.state), 32'd2);
        chk("post_count", 32'(bus.count), 32'd20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_post_state", 32'(bus.state), 32'd0);
        chk("rst_post_count", 32'(bus.count), 32'd0);
        chk("rst_post_valid", 32'(bus.rd_valid), 32'd0);
        arm(1'b1);
        for (int k = 0; k < 24; k++) retire(32'(4 * k), 1'b0);
        chk("rearm_done", 32'(bus.state), 32'd3);
        chk("rearm_count", 32'(bus.count), 32'd22);
        drain(0);

        // random captures
        for (int t = 0; t < 25; t++) begin
            int cyc = 0;
            set_trig(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, 1'($urandom_range(0, 1)));
            arm(1'($urandom_range(0, 1)));
            while (m_state != 3 && cyc < 200) begin
                bus.rvfi_valid = ($urandom_range(0, 3) != 0);
                set_rec(32'($urandom_range(0, 63)) << 2, ($urandom_range(0, 15) == 0));
                bus.abort    = ($urandom_range(0, 99) == 0);
                bus.arm      = ($urandom_range(0, 49) == 0);
                bus.mode     = 1'($urandom_range(0, 1));
                bus.rd_ready = 1'($urandom_range(0, 1));
                tick();
                cyc++;
            end
            bus.rvfi_valid = 0; bus.abort = 0; bus.arm = 0; bus.rd_ready = 0;
            if (m_state != 3) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
            end
            drain(int'($urandom_range(0, 2)));
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
